memwb_skid_stage: RTL and testbench

//  Parametrised MEM->WB pipeline register; successor to the fixed stall/bubble flop stage.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/memwb_skid_stage_sat_counter.sv | 31 +++
 rtl/memwb_skid_stage.sv | 138 +++++++++++++
 tb/tb_memwb_skid_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared MEM->WB pipeline types: the packed writeback payload and the skid-stage state encoding.
// Imported by memwb_skid_stage; the optional perf counters are gated by MEMWB_PERF_CNT_EN.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] ram_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_sign;
    logic [1:0]  mem_sel;
    logic [31:0] result;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] pc;
  } memwb_payload_t;

  localparam int MEMWB_PAYLOAD_W = $bits(memwb_payload_t);

  localparam logic [1:0] MEMWB_ST_EMPTY = 2'd0;
  localparam logic [1:0] MEMWB_ST_ONE   = 2'd1;
  localparam logic [1:0] MEMWB_ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = MEMWB_ST_EMPTY,
    ST_ONE   = MEMWB_ST_ONE,
    ST_TWO   = MEMWB_ST_TWO
  } memwb_state_e;

  // Entry count held in each state, reported on the occupancy port.
  function automatic logic [1:0] occ_of_state(memwb_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/memwb_skid_stage_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by async active-low reset.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM->WB pipeline register with a 2-entry skid buffer so in_ready never depends combinationally
// on out_ready. Define MEMWB_PERF_CNT_EN to add the stall/bubble performance counters.
module memwb_skid_stage
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W       = MEMWB_PAYLOAD_W,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
`ifdef MEMWB_PERF_CNT_EN
  ,
  parameter int CNT_W           = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
`ifdef MEMWB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  memwb_state_e         state_q;
  memwb_state_e         state_d;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] main_d;
  logic [PAYLOAD_W-1:0] skid_q;
  logic [PAYLOAD_W-1:0] skid_d;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic [1:0]           occ_q;

  logic push;
  logic pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Flush wins over everything; a push in the flush cycle is accepted upstream but dropped here.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      skid_d  = '0;
      if (CLEAR_ON_BUBBLE) begin
        main_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_BUBBLE) begin
              main_d = '0;
            end
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they land in flops alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_TWO);
      occ_q       <= occ_of_state(state_d);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

`ifdef MEMWB_PERF_CNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid_q & ~out_ready),
    .value (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~out_valid_q),
    .value (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed bench for memwb_skid_stage: queue scoreboard of accepted payloads, immediate assertions.
// Counter checks are compiled in when MEMWB_PERF_CNT_EN is defined.
module tb_memwb_skid_stage;
  import pipe_pkg::*;

  localparam int W = MEMWB_PAYLOAD_W;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] inData;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] outData;
  logic [1:0]   occupancy;

  logic         ncInReady;
  logic         ncOutValid;
  logic [W-1:0] ncOutData;
  logic [1:0]   ncOccupancy;

`ifdef MEMWB_PERF_CNT_EN
  logic [3:0]   stallCnt;
  logic [3:0]   bubbleCnt;
  logic [31:0]  ncStallCnt;
  logic [31:0]  ncBubbleCnt;
  int           stallExp;
  int           bubbleExp;
`endif

  int nAsserts;
  int nFail;
  logic [W-1:0] expQ[$];

  memwb_skid_stage #(
    .PAYLOAD_W       (W),
    .CLEAR_ON_BUBBLE (1'b1)
`ifdef MEMWB_PERF_CNT_EN
    ,
    .CNT_W           (4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .occupancy  (occupancy)
`ifdef MEMWB_PERF_CNT_EN
    ,
    .stall_cnt  (stallCnt),
    .bubble_cnt (bubbleCnt)
`endif
  );

  // Twin instance fed the same stimulus, but keeping its last payload when it drains.
  memwb_skid_stage #(
    .PAYLOAD_W       (W),
    .CLEAR_ON_BUBBLE (1'b0)
  ) dut_nc (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (ncInReady),
    .in_data    (inData),
    .out_valid  (ncOutValid),
    .out_ready  (outReady),
    .out_data   (ncOutData),
    .occupancy  (ncOccupancy)
`ifdef MEMWB_PERF_CNT_EN
    ,
    .stall_cnt  (ncStallCnt),
    .bubble_cnt (ncBubbleCnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] mkPayload(int n);
    memwb_payload_t p;
    p.ram_rdata = 32'hD000_0000 ^ n;
    p.mem_read  = n[0];
    p.mem_write = n[1];
    p.mem_sign  = n[2];
    p.mem_sel   = n[1:0];
    p.result    = 32'h5A5A_0000 + n;
    p.reg_we    = 1'b1;
    p.reg_waddr = n[4:0];
    p.pc        = 32'h0000_1000 + (n << 2);
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
  endtask

  // Update the scoreboard from the handshake the model predicts, then advance one edge and check.
  task automatic clockCycle();
    bit push;
    bit pop;
    logic [W-1:0] head;
    push = inValid && (expQ.size() < 2);
    pop  = outReady && (expQ.size() > 0);
`ifdef MEMWB_PERF_CNT_EN
    if ((expQ.size() > 0) && !outReady && stallExp < 15) stallExp++;
    if ((expQ.size() == 0) && bubbleExp < 15) bubbleExp++;
`endif
    if (flush) begin
      expQ.delete();
    end else begin
      if (pop) begin
        head = expQ.pop_front();
        checkOutput("pop data", 128'(outData), 128'(head));
      end
      if (push) expQ.push_back(inData);
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", 128'(outValid), 128'(expQ.size() > 0));
    checkOutput("in_ready", 128'(inReady), 128'(expQ.size() < 2));
    checkOutput("occupancy", 128'(occupancy), 128'(expQ.size()));
    if (expQ.size() == 0) checkOutput("empty data zero", 128'(outData), 128'(0));
`ifdef MEMWB_PERF_CNT_EN
    checkOutput("stall_cnt", 128'(stallCnt), 128'(stallExp));
    checkOutput("bubble_cnt", 128'(bubbleCnt), 128'(bubbleExp));
`endif
  endtask

  initial begin
    nAsserts = 0;
    nFail    = 0;
`ifdef MEMWB_PERF_CNT_EN
    stallExp  = 0;
    bubbleExp = 0;
`endif
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 128'(outValid), 128'(0));
    checkOutput("reset in_ready", 128'(inReady), 128'(1));
    checkOutput("reset occupancy", 128'(occupancy), 128'(0));
    checkOutput("reset out_data", 128'(outData), 128'(0));
    rst = 1'b1;

    $display("[TB] streaming A,B,C with out_ready=1");
    applyStimulus(1'b1, mkPayload(1), 1'b1, 1'b0);
    clockCycle();
    checkOutput("first latency data", 128'(outData), 128'(mkPayload(1)));
    applyStimulus(1'b1, mkPayload(2), 1'b1, 1'b0);
    clockCycle();
    applyStimulus(1'b1, mkPayload(3), 1'b1, 1'b0);
    clockCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    clockCycle();
    checkOutput("nc out_valid drained", 128'(ncOutValid), 128'(0));
    checkOutput("nc keeps last data", 128'(ncOutData), 128'(mkPayload(3)));
    clockCycle();

    $display("[TB] back-pressure fills skid buffer");
    applyStimulus(1'b1, mkPayload(4), 1'b0, 1'b0);
    clockCycle();
    applyStimulus(1'b1, mkPayload(5), 1'b0, 1'b0);
    clockCycle();
    checkOutput("two held occupancy", 128'(occupancy), 128'(2));
    checkOutput("two held in_ready", 128'(inReady), 128'(0));
    applyStimulus(1'b1, mkPayload(6), 1'b0, 1'b0);
    clockCycle();
    clockCycle();
    checkOutput("stable while stalled", 128'(outData), 128'(mkPayload(4)));
    applyStimulus(1'b1, mkPayload(6), 1'b1, 1'b0);
    clockCycle();
    clockCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    clockCycle();
    clockCycle();
    checkOutput("scoreboard drained", 128'(expQ.size()), 128'(0));

    $display("[TB] flush from TWO with same-cycle push");
    applyStimulus(1'b1, mkPayload(7), 1'b0, 1'b0);
    clockCycle();
    applyStimulus(1'b1, mkPayload(8), 1'b0, 1'b0);
    clockCycle();
    applyStimulus(1'b1, mkPayload(9), 1'b0, 1'b1);
    clockCycle();
    checkOutput("flush occupancy", 128'(occupancy), 128'(0));
    checkOutput("flush out_data", 128'(outData), 128'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    clockCycle();
    applyStimulus(1'b1, mkPayload(10), 1'b1, 1'b0);
    clockCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    clockCycle();
    clockCycle();

    $display("[TB] async reset while holding two entries");
    applyStimulus(1'b1, mkPayload(11), 1'b0, 1'b0);
    clockCycle();
    applyStimulus(1'b1, mkPayload(12), 1'b0, 1'b0);
    clockCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst out_valid", 128'(outValid), 128'(0));
    checkOutput("async rst occupancy", 128'(occupancy), 128'(0));
    checkOutput("async rst in_ready", 128'(inReady), 128'(1));
    checkOutput("async rst out_data", 128'(outData), 128'(0));
    expQ.delete();
`ifdef MEMWB_PERF_CNT_EN
    stallExp  = 0;
    bubbleExp = 0;
`endif
    #2;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    clockCycle();
    applyStimulus(1'b1, mkPayload(13), 1'b1, 1'b0);
    clockCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    clockCycle();

`ifdef MEMWB_PERF_CNT_EN
    $display("[TB] performance counter saturation");
    applyStimulus(1'b1, mkPayload(14), 1'b0, 1'b0);
    clockCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) clockCycle();
    checkOutput("stall saturated", 128'(stallCnt), 128'(15));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) clockCycle();
    checkOutput("stall unchanged when idle", 128'(stallCnt), 128'(15));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
